// File: rtl/rr3_pkg.sv
// Shared types and helpers for the three-way round-robin arbiter.
package rr3_pkg;

  localparam int NREQ = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  typedef logic [1:0] ptr_t;

  // Encoding 3 is unreachable but treated as 0, so its successor is 1.
  function automatic ptr_t next_idx(input ptr_t i);
    ptr_t n;
    case (i)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      2'd2:    n = 2'd0;
      default: n = 2'd1;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] pick(input logic [2:0] req, input logic [2:0] mask,
                                      input ptr_t ptr);
    logic [2:0] elig;
    logic [2:0] win;
    ptr_t       p;
    elig = req & ~mask;
    win  = 3'b000;
    p    = (ptr == 2'd3) ? 2'd0 : ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (win == 3'b000 && elig[p]) win[p] = 1'b1;
      p = next_idx(p);
    end
    return win;
  endfunction

endpackage

// File: rtl/rr3_arbiter_ptr.sv
// Mod-3 priority pointer register; loads a new index when advanced.
module rr3_ptr
  import rr3_pkg::*;
(
  input  logic clk,
  input  logic res,
  input  logic adv,
  input  ptr_t ld,
  output ptr_t ptr
);

  always_ff @(posedge clk) begin
    if (!res)     ptr <= 2'd0;
    else if (adv) ptr <= (ld == 2'd3) ? 2'd0 : ld;
  end

endmodule

// File: rtl/rr3_arbiter.sv
// Three-requester round-robin arbiter with held ownership and registered one-hot grant.
// Optional hold watchdog compiled in with RR3_TIMEOUT_EN.
module rr3_arbiter
  import rr3_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       res,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] ptr,
  output logic       busy,
  output logic       timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr3_arbiter: MAX_HOLD must be in 1..255");
  end

  state_t     state;
  ptr_t       owner;
  logic [2:0] win;
  logic [2:0] mask;
  logic       release_own;
  logic       revoke;
  logic       adv;

  assign owner       = gnt[0] ? 2'd0 : (gnt[1] ? 2'd1 : 2'd2);
  assign release_own = (state == OWN) && !req[owner];
  assign win         = pick(req, mask, ptr);
  assign adv         = release_own || revoke;
  assign busy        = |gnt;

`ifdef RR3_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  logic [7:0] hold_cnt;
  logic       timeout_q;

  assign revoke  = (state == OWN) && req[owner] && (hold_cnt == HOLD_LIM);
  assign timeout = timeout_q;

  // A mask bit survives only while its requester keeps req high.
  always_ff @(posedge clk) begin
    if (!res) begin
      hold_cnt  <= 8'd0;
      mask      <= 3'b000;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= revoke;
      mask      <= (mask & req) | (revoke ? gnt : 3'b000);
      if (state == IDLE) hold_cnt <= 8'd0;
      else               hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign revoke  = 1'b0;
  assign mask    = 3'b000;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!res) begin
      state <= IDLE;
      gnt   <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (win != 3'b000) begin
            gnt   <= win;
            state <= OWN;
          end
        end
        default: begin
          if (release_own || revoke) begin
            gnt   <= 3'b000;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  rr3_ptr u_ptr (
    .clk (clk),
    .res (res),
    .adv (adv),
    .ld  (next_idx(owner)),
    .ptr (ptr)
  );

endmodule

// File: doc/rr3_arbiter.md
# rr3_arbiter

Round-robin arbiter that shares one resource among three requesters, using a mod-3 rotating priority pointer. Sits in front of the shared counter/datapath resource and issues a registered one-hot grant. Ownership is held until the owner releases the resource. An optional watchdog revokes a grant that is held too long.

## Interface

**Parameters**
- `MAX_HOLD`, default 15: maximum cycles a grant may be held when the watchdog is compiled in; legal range 1..255.

**Ports**
- `clk`  input  1: clock; all logic is rising-edge.
- `res`  input  1: reset, synchronous and active-low; one clock, synchronous active-low reset.
- `req`  input  3: request per requester; level, held high for the whole use.
- `gnt`  output  3: one-hot or zero grant; registered.
- `ptr`  output  2: current highest-priority requester index, 0..2.
- `busy`  output  1: high while any grant is active; equals OR of `gnt`.
- `timeout`  output  1: one-cycle pulse on watchdog revoke; tied 0 when the watchdog is compiled out.

## Operation

**Reset** (`res`=0 at an edge):
- `gnt`=000, `ptr`=0, `busy`=0, `timeout`=0.
- State IDLE; hold count 0; mask 000.
- A reset during an active grant drops `gnt` at that same edge.

**IDLE state:**
- Search order is `ptr`, (`ptr`+1) mod 3, then (`ptr`+2) mod 3.
- The first requester with `req`=1 and mask=0 wins.
- At the next edge: `gnt`[winner]=1 and the state moves to OWN.
- If there are no eligible requests, stay in IDLE with `gnt`=000.

**OWN state:**
- `gnt` is held while `req`[owner]=1; other requests are ignored.
- When `req`[owner] is sampled 0, at that edge: `gnt`=000, `ptr` = (owner+1) mod 3, and the state returns to IDLE.

**Pointer rules:**
- `ptr` only advances on release or revoke.
- `ptr` is never 3. The encoding 3 is unreachable, but if present it is decoded as 0.

**Simultaneous events:**
- Requests arriving in the same cycle are resolved purely by pointer order.
- A new request appearing on the release edge is evaluated in the following IDLE cycle.

## Timing

- Grant latency is 1 cycle from the edge that samples `req` high in IDLE.
- Release latency is 1 cycle: `gnt` falls at the edge that samples `req`[owner]=0.
- There is a mandatory dead cycle (IDLE, `gnt`=000) between consecutive grants, so the minimum grant-to-grant spacing is 2 cycles.
- `busy` and `ptr` are registered and change on the same edges as `gnt`.
- A requester that drops `req` before it is granted loses the request; there is no internal queueing.

## Configuration

Macro: `RR3_TIMEOUT_EN`.

**Defined:**
- An 8-bit hold counter clears on grant and increments each cycle in OWN.
- When the count reaches `MAX_HOLD` with `req`[owner] still 1, at the next edge:
  - `gnt`=000 and `timeout`=1 for one cycle;
  - `ptr` = (owner+1) mod 3;
  - state returns to IDLE;
  - mask[owner] is set.
- A masked requester is ineligible until its `req` is sampled 0, which clears its mask bit.
- A normal release on the same edge as the count reaching `MAX_HOLD` takes priority: no timeout, no mask.

**Undefined:**
- The counter and mask are absent and `timeout` is constant 0.
- A grant may be held indefinitely.

## Structure

**Package `rr3_pkg`:**
- `NREQ`=3.
- State enum {IDLE, OWN}.
- 2-bit pointer type.
- Function `next_idx(i)` returning (i+1) mod 3.
- Function `pick(req, mask, ptr)` returning a one-hot winner or 000.

**Sub-module `rr3_ptr`:** mod-3 pointer register.
- Inputs: `clk`, `res`, advance enable, load value.
- Output: `ptr`.
- This isolates the wrap-around logic.

## Test plan

1. Reset, then `req`=001 at cycle 2 → `gnt`=001 at cycle 3. Drop `req` at cycle 6 → `gnt`=000 at cycle 7 and `ptr`=1.
2. With `ptr`=0, `req`=111 held, each owner releasing after 2 cycles → grant order 001, 010, 100, 001, each separated by one IDLE cycle. `ptr` sequence 1, 2, 0.
3. With `ptr`=2, `req`=011 → `gnt`=001 (wrap-around); after release, `ptr`=1.
4. Assert `res`=0 while `gnt`=010 → `gnt`=000, `ptr`=0, `busy`=0 at that edge; with `req`=010 still high, the grant reappears 1 cycle after `res`=1.
5. Watchdog (`RR3_TIMEOUT_EN`, `MAX_HOLD`=4):
   - `req`=001 held → `gnt`=001 for 5 cycles (count 0..4), then the next edge gives `gnt`=000, `timeout`=1 and `ptr`=1.
   - Requester 0 is not regranted until its `req` toggles low and high again.
6. Watchdog boundary: owner drops `req` on the cycle the count reaches `MAX_HOLD` → normal release with `timeout`=0 and no mask set.
